// File: rtl/wba_pkg.sv
// wba_pkg: shared FSM state type and burst counter width for wired_bus_arb
package wba_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting one past the last winner
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   win,
  output logic            valid
);
  logic [IW-1:0] idx;
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    win = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (req[idx]) begin
        win = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wired_bus_arb.sv
// wired_bus_arb: round-robin shared-bus arbiter with bursts and turnaround (WBA_PARK_EN parks bus low in IDLE)
module wired_bus_arb
  import wba_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][DW-1:0]  wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     bus_oe,
  output logic [DW-1:0]            bus_dout,
  output logic                     idle
);
  localparam int IW = $clog2(NREQ);
  state_t st, nxt;
  logic [IW-1:0] last, pick;
  logic pick_ok, grab, done, park;
  logic [CNT_W-1:0] cnt;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(req), .last(last), .win(pick), .valid(pick_ok));
  // next-state decision: burst end on release or limit, new grant from IDLE/TURN
  always_comb begin
    grab = st != DRIVE && pick_ok;
    done = st == DRIVE && (!req[last] || cnt == CNT_W'(MAX_BURST));
    nxt = st == DRIVE ? (done ? TURN : DRIVE) : (pick_ok ? DRIVE : IDLE);
`ifdef WBA_PARK_EN
    park = nxt == IDLE;
`else
    park = 1'b0;
`endif
  end
  // FSM with registered grant, enable, idle flag and burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      gnt <= '0;
      bus_oe <= 1'b0;
      idle <= 1'b1;
      cnt <= '0;
      last <= '0;
    end else begin
      st <= nxt;
      last <= grab ? pick : last;
      gnt <= nxt == DRIVE ? (grab ? NREQ'(1) << pick : gnt) : '0;
      bus_oe <= nxt == DRIVE || park;
      idle <= nxt == IDLE;
      cnt <= grab ? CNT_W'(1) : (nxt == DRIVE ? cnt + 1'b1 : '0);
    end
  end
  assign bus_dout = st == DRIVE ? wdata[last] : '0;
endmodule
